// File: rtl/seven_seg_press_counter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : seven_seg_press_counter_if                              |
// | Purpose  : Switch inputs and counter/segment outputs of the        |
// |            N-channel seven-segment press counter.                  |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface seven_seg_press_counter_if #(
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]   i_Switch;
    logic                i_Down;
    logic [NUM_CH-1:0]   o_Press_Pulse;
    logic [4*NUM_CH-1:0] o_Count;
    logic [7*NUM_CH-1:0] o_Segment;

    // Board / testbench side: drives switches, observes the display
    modport master (
        output i_Switch,
        output i_Down,
        input  o_Press_Pulse,
        input  o_Count,
        input  o_Segment
    );

    // Counter side
    modport slave (
        input  i_Switch,
        input  i_Down,
        output o_Press_Pulse,
        output o_Count,
        output o_Segment
    );
endinterface
`default_nettype wire

// File: rtl/seven_seg_press_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : seven_seg_press_counter                                 |
// | Purpose  : Per channel: 2-FF synchroniser, debouncer, press FSM    |
// |            with optional auto-repeat, hex/decimal up/down counter  |
// |            and registered seven-segment encoder.                   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module seven_seg_press_counter #(
    parameter int NUM_CH          = 2,
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int REPEAT_CYCLES   = 0,
    parameter int DECIMAL         = 0,
    parameter int ACTIVE_LOW      = 1
) (
    input  wire logic                    i_Clk,
    input  wire logic                    i_Rst_L,
    seven_seg_press_counter_if.slave     bus
);

    localparam int c_DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int c_RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [c_DB_W-1:0]  c_DB_MAX  = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_RPT_W-1:0] c_RPT_MAX = c_RPT_W'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
    localparam logic [6:0]         c_POL     = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    // Active-high ABCDEFG pattern, A in bit 6
    function automatic logic [6:0] seg_enc(input logic [3:0] v);
        logic [6:0] s;
        s = 7'b0000000;
        case (v)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            4'hF: s = 7'b1000111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // One count step with hex or decimal wrap in either direction
    function automatic logic [3:0] count_step(input logic [3:0] v, input logic down);
        logic [3:0] n;
        if (down) begin
            if (v == 4'h0) n = (DECIMAL != 0) ? 4'h9 : 4'hF;
            else           n = v - 4'h1;
        end else begin
            if ((DECIMAL != 0) && (v == 4'h9)) n = 4'h0;
            else                               n = v + 4'h1;
        end
        return n;
    endfunction

    localparam logic [6:0] c_SEG_RST = c_POL ^ seg_enc(4'h0);

    // Per-channel results, gathered into the packed outputs below
    logic       w_pulse [NUM_CH];
    logic [3:0] w_count [NUM_CH];
    logic [6:0] w_seg   [NUM_CH];

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic [1:0]         r_sync;
            logic               r_deb;
            logic [c_DB_W-1:0]  r_db_cnt;
            state_t             r_state;
            state_t             w_state_nxt;
            logic [c_RPT_W-1:0] r_rpt;
            logic [c_RPT_W-1:0] w_rpt_nxt;
            logic               w_pulse_nxt;
            logic               r_pulse;
            logic [3:0]         r_count;
            logic [6:0]         r_seg;
            logic               w_diff;
            logic               w_flip;
            logic               w_rise;
            logic               w_fall;

            // Debounced level changes on the cycle the Nth differing sample is seen,
            // so the FSM reacts to the flip without an extra register stage.
            assign w_diff = (r_sync[1] != r_deb);
            assign w_flip = w_diff && (r_db_cnt == c_DB_MAX);
            assign w_rise = w_flip && r_sync[1];
            assign w_fall = w_flip && !r_sync[1];

            // Two-flop synchroniser for the asynchronous switch
            always_ff @(posedge i_Clk or negedge i_Rst_L) begin
                if (!i_Rst_L) r_sync <= 2'b00;
                else          r_sync <= {r_sync[0], bus.i_Switch[c]};
            end

            // Debouncer: count consecutive differing samples, flip on the last one
            always_ff @(posedge i_Clk or negedge i_Rst_L) begin
                if (!i_Rst_L) begin
                    r_deb    <= 1'b0;
                    r_db_cnt <= '0;
                end else if (w_flip) begin
                    r_deb    <= r_sync[1];
                    r_db_cnt <= '0;
                end else if (w_diff) begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end else begin
                    r_db_cnt <= '0;
                end
            end

            // Press FSM state and repeat timer registers
            always_ff @(posedge i_Clk or negedge i_Rst_L) begin
                if (!i_Rst_L) begin
                    r_state <= ST_IDLE;
                    r_rpt   <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_rpt   <= w_rpt_nxt;
                end
            end

            // Press FSM next state: a release wins over a coincident repeat expiry
            always_comb begin
                w_state_nxt = r_state;
                w_rpt_nxt   = r_rpt;
                w_pulse_nxt = 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (w_rise) begin
                            w_pulse_nxt = 1'b1;
                            w_state_nxt = ST_HELD;
                            w_rpt_nxt   = '0;
                        end
                    end
                    ST_HELD: begin
                        if (w_fall) begin
                            w_state_nxt = ST_IDLE;
                            w_rpt_nxt   = '0;
                        end else if (REPEAT_CYCLES > 0) begin
                            if (r_rpt == c_RPT_MAX) begin
                                w_pulse_nxt = 1'b1;
                                w_rpt_nxt   = '0;
                            end else begin
                                w_rpt_nxt = r_rpt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_rpt_nxt   = '0;
                    end
                endcase
            end

            // Pulse and count register together; the segment follows the count a cycle later
            always_ff @(posedge i_Clk or negedge i_Rst_L) begin
                if (!i_Rst_L) begin
                    r_pulse <= 1'b0;
                    r_count <= 4'h0;
                    r_seg   <= c_SEG_RST;
                end else begin
                    r_pulse <= w_pulse_nxt;
                    if (w_pulse_nxt) r_count <= count_step(r_count, bus.i_Down);
                    r_seg   <= c_POL ^ seg_enc(r_count);
                end
            end

            assign w_pulse[c] = r_pulse;
            assign w_count[c] = r_count;
            assign w_seg[c]   = r_seg;
        end
    endgenerate

    // Pack per-channel registers onto the output buses
    always_comb begin
        bus.o_Press_Pulse = '0;
        bus.o_Count       = '0;
        bus.o_Segment     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.o_Press_Pulse[i]     = w_pulse[i];
            bus.o_Count[4*i +: 4]    = w_count[i];
            bus.o_Segment[7*i +: 7]  = w_seg[i];
        end
    end

endmodule
`default_nettype wire

// File: doc/seven_seg_press_counter.md
# seven_seg_press_counter

Parametrised N-channel press counter for the seven-segment boards. Each channel synchronises and debounces one push-button, counts debounced presses (up or down, hex or decimal, with optional auto-repeat while held) and drives one seven-segment digit. It sits between the raw board switches and the segment pins in the top level.

## Interface

Parameters:
- NUM_CH, 2, number of independent channels (switch + counter + digit), 1..8
- DEBOUNCE_CYCLES, 10, consecutive stable samples required to accept a level change, >= 2
- REPEAT_CYCLES, 0, auto-repeat period while held; 0 disables auto-repeat
- DECIMAL, 0, 0 = hex count 0..F, 1 = decimal count 0..9
- ACTIVE_LOW, 1, 1 = segment outputs inverted (lit = 0)

Ports:
- i_Clk  in  1  system clock (12 MHz on the board)
- i_Rst_L  in  1  reset; one clock; reset is asynchronous and active-low
- i_Switch  in  NUM_CH  raw switch levels, 1 = pressed, asynchronous to i_Clk
- i_Down  in  1  count direction, 0 = up, 1 = down; shared by all channels
- o_Press_Pulse  out  NUM_CH  one-cycle pulse per accepted press/repeat, per channel
- o_Count  out  4*NUM_CH  channel c count at [4c+3:4c]
- o_Segment  out  7*NUM_CH  channel c at [7c+6:7c], order {A,B,C,D,E,F,G}, A is the MSB

## Operation

- Per channel: 2-FF synchroniser -> debouncer -> press FSM -> 4-bit counter -> segment encoder register. Channels are fully independent.
- Debouncer: holds a debounced level (reset 0) and a stable counter. While the synchronised level differs from the debounced level, the counter increments. Any cycle where they are equal clears it. When DEBOUNCE_CYCLES consecutive differing samples have been seen, the debounced level flips and the counter clears. Glitches shorter than DEBOUNCE_CYCLES have no effect.
- Press FSM states:
  - IDLE: on debounced rise -> emit pulse, go HELD, clear repeat timer.
  - HELD: on debounced fall -> IDLE. Otherwise, if REPEAT_CYCLES > 0, the repeat timer counts. At REPEAT_CYCLES it emits a pulse and clears.
- Counter: on a pulse, count +1 when i_Down = 0, or -1 when i_Down = 1. i_Down is sampled in the pulse cycle.
  - Hex wraps F->0 up and 0->F down.
  - Decimal wraps 9->0 up and 0->9 down. Values >9 are unreachable in decimal mode.
- Encoder, active-high ABCDEFG: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111. ACTIVE_LOW inverts all 7 bits.
- Reset (async assert, any state): debounced levels 0, FSMs IDLE, timers 0, o_Press_Pulse 0, o_Count 0, o_Segment = encoding of 0 (0000001 per channel with ACTIVE_LOW=1).
- Reset mid-debounce or mid-hold aborts it with no pulse. A switch held through reset release is accepted as one fresh press after the normal debounce latency.
- Simultaneous presses on several channels each count in the same cycle, with no arbitration.

## Timing

- Edge 0 is the first i_Clk edge that samples i_Switch[c] = 1 (input then stable).
  - o_Press_Pulse[c] and the new o_Count are registered at edge 1 + DEBOUNCE_CYCLES.
  - o_Segment updates one edge later.
- Release latency is the same, with no pulse.
- Auto-repeat: subsequent pulses every REPEAT_CYCLES edges after the first pulse while the debounced level stays 1.
- The pulse is exactly one cycle wide. At most one count step per channel per cycle.
- Outputs are all registered. There are no combinational paths from inputs to outputs.

## Test plan

- Reset: hold i_Rst_L=0, toggle switches -> o_Count=0, o_Press_Pulse=0, o_Segment=14'b0000001_0000001 (defaults).
- Single press: default params, i_Switch[0] high 20 cycles, then low 20 cycles.
  - Required: one o_Press_Pulse[0] at edge 11; o_Count[3:0]=1 at that edge; o_Segment[6:0]=1001111 one edge later; channel 1 unchanged.
- Bounce rejection: pulse i_Switch[1] high for 5 cycles, 3 times, separated by 5-cycle lows -> no pulse, count stays 0. Then a stable 20-cycle press -> count 1.
- Wrap and direction:
  - DECIMAL=1: 10 presses from 0 -> count 0 (9->0 wrap).
  - Then i_Down=1, one press -> count 9.
  - DECIMAL=0: from 0 with i_Down=1 -> F, seg 0111000 (active-low).
- Auto-repeat: REPEAT_CYCLES=50, hold i_Switch[0] for 200 cycles -> pulses at edges 11, 61, 111, 161, count 4. Release -> no further pulses.
- Simultaneous press and reset mid-hold:
  - Both switches rise together -> both counts increment in the same cycle.
  - Assert reset during HELD -> all outputs return to reset values immediately.
  - Switch kept high after release -> exactly one new pulse 11 edges after reset deassertion.
